// File: rtl/tnn_pkg.sv
// rtl/tnn_pkg.sv - shared widths, FSM states and ternary encodings for the ternary neuron sequencer
package tnn_pkg;
  localparam int N_IN = 21;
  localparam int CW   = 5;
  localparam int DW   = 6;

  typedef enum logic [1:0] {IDLE, POS, NEG, OUT} state_t;

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_NEG  = 2'b11;
  localparam logic [1:0] ACT_ZERO = 2'b00;
endpackage

// File: rtl/tnn_popcount21.sv
// rtl/tnn_popcount21.sv - combinational 21-input popcount core shared by both neuron phases
module tnn_popcount21
  import tnn_pkg::*;
(
  input  logic [N_IN-1:0] bits,
  output logic [CW-1:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N_IN; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/tnn_neuron_seq.sv
// rtl/tnn_neuron_seq.sv - ternary neuron sequencer, one popcount reused for positive then negative phase
// Optional TNN_DIFF_OUT_EN adds the registered out_diff port.
module tnn_neuron_seq #(
  parameter int N_IN = 21,
  parameter int CW   = 5,
  parameter int DW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_x,
  input  logic [N_IN-1:0] in_pos,
  input  logic [N_IN-1:0] in_neg,
  input  logic [DW-1:0]   in_thr_hi,
  input  logic [DW-1:0]   in_thr_lo,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_act
`ifdef TNN_DIFF_OUT_EN
  ,
  output logic [DW-1:0]   out_diff
`endif
);
  import tnn_pkg::*;

  state_t            state;
  logic [N_IN-1:0]   x_r;
  logic [N_IN-1:0]   pos_r;
  logic [N_IN-1:0]   neg_eff_r;
  logic [DW-1:0]     thr_hi_r;
  logic [DW-1:0]     thr_lo_r;
  logic [CW-1:0]     cnt_pos;
  logic [N_IN-1:0]   core_in;
  logic [CW-1:0]     core_out;
  logic [DW-1:0]     diff;
  logic [1:0]        act_nxt;

  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    core_in = '0;
    case (state)
      POS:     core_in = x_r & pos_r;
      NEG:     core_in = x_r & neg_eff_r;
      default: core_in = '0;
    endcase
  end

  tnn_popcount21 u_popcount (
    .bits  (core_in),
    .count (core_out)
  );

  // Both counts are at most 31, so a 6-bit difference never wraps.
  assign diff = {1'b0, cnt_pos} - {1'b0, core_out};

  always_comb begin
    act_nxt = ACT_ZERO;
    if ($signed(diff) >= $signed(thr_hi_r)) begin
      act_nxt = ACT_POS;
    end else if ($signed(diff) <= $signed(thr_lo_r)) begin
      act_nxt = ACT_NEG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_r       <= '0;
      pos_r     <= '0;
      neg_eff_r <= '0;
      thr_hi_r  <= '0;
      thr_lo_r  <= '0;
      cnt_pos   <= '0;
      out_valid <= 1'b0;
      out_act   <= ACT_ZERO;
`ifdef TNN_DIFF_OUT_EN
      out_diff  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r       <= in_x;
            pos_r     <= in_pos;
            // A bit set in both masks counts as positive only.
            neg_eff_r <= in_neg & ~in_pos;
            thr_hi_r  <= in_thr_hi;
            thr_lo_r  <= in_thr_lo;
            state     <= POS;
          end
        end
        POS: begin
          cnt_pos <= core_out;
          state   <= NEG;
        end
        NEG: begin
          out_act   <= act_nxt;
`ifdef TNN_DIFF_OUT_EN
          out_diff  <= diff;
`endif
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_neuron_seq.sv
// tb/tb_tnn_neuron_seq.sv - scoreboard bench for tnn_neuron_seq; checks out_diff when TNN_DIFF_OUT_EN is defined
module tb_tnn_neuron_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_x;
  logic [20:0] in_pos;
  logic [20:0] in_neg;
  logic [5:0]  in_thr_hi;
  logic [5:0]  in_thr_lo;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_act;
`ifdef TNN_DIFF_OUT_EN
  logic [5:0]  out_diff;
`endif

  always #5 clk = ~clk;

  tnn_neuron_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_pos    (in_pos),
    .in_neg    (in_neg),
    .in_thr_hi (in_thr_hi),
    .in_thr_lo (in_thr_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_act   (out_act)
`ifdef TNN_DIFF_OUT_EN
    ,
    .out_diff  (out_diff)
`endif
  );

  typedef struct {
    logic [1:0] act;
    logic [5:0] diff;
    int         t;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  bit         lat_chk = 1'b0;
  int         prev_acc = -1;
  bit         stall_prev = 1'b0;
  bit         rnd_done = 1'b0;
  logic [1:0] held_act;
  logic [1:0] last_act;
`ifdef TNN_DIFF_OUT_EN
  logic [5:0] held_diff;
  logic [5:0] last_diff;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Golden model: exact popcount, overlap counts positive, +1 test first.
  function automatic exp_t model(input logic [20:0] x, input logic [20:0] pos,
                                 input logic [20:0] neg, input logic [5:0] hi,
                                 input logic [5:0] lo);
    exp_t e;
    int   p, n, d, h, l;
    p = $countones(x & pos);
    n = $countones(x & neg & ~pos);
    d = p - n;
    h = $signed(hi);
    l = $signed(lo);
    if (d >= h)      e.act = 2'b01;
    else if (d <= l) e.act = 2'b11;
    else             e.act = 2'b00;
    e.diff = 6'(d);
    e.t    = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push on accepted request, pop and compare on delivered result.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_act", out_act, held_act);
`ifdef TNN_DIFF_OUT_EN
        check("hold_diff", out_diff, held_diff);
`endif
      end
      stall_prev = out_valid && !out_ready;
      held_act   = out_act;
`ifdef TNN_DIFF_OUT_EN
      held_diff  = out_diff;
`endif
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("act", out_act, e.act);
          last_act = out_act;
`ifdef TNN_DIFF_OUT_EN
          check("diff", out_diff, e.diff);
          last_diff = out_diff;
`endif
          if (lat_chk) check("latency", (cyc + 1) - e.t, 3);
        end
      end
      if (in_valid && in_ready) begin
        e   = model(in_x, in_pos, in_neg, in_thr_hi, in_thr_lo);
        e.t = cyc + 1;
        sb_q.push_back(e);
        if (lat_chk && prev_acc >= 0) check("period", e.t - prev_acc, 4);
        prev_acc = e.t;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [20:0] x, input logic [20:0] pos, input logic [20:0] neg,
                      input logic [5:0] hi, input logic [5:0] lo);
    bit ok;
    in_x = x; in_pos = pos; in_neg = neg; in_thr_hi = hi; in_thr_lo = lo;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  task automatic run(input string tag, input logic [20:0] x, input logic [20:0] pos,
                     input logic [20:0] neg, input logic [5:0] hi, input logic [5:0] lo,
                     input logic [1:0] eact, input logic [5:0] ediff);
    send(x, pos, neg, hi, lo);
    drain();
    check(tag, last_act, eact);
`ifdef TNN_DIFF_OUT_EN
    check({tag, "_diff"}, last_diff, ediff);
`else
    if (ediff === 6'bx) check({tag, "_diff_x"}, 0, 1);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_pos = '0; in_neg = '0; in_thr_hi = '0; in_thr_lo = '0;

    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_act", out_act, 0);
      check("rst_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    @(posedge clk); #1;

    run("basic_zero", 21'h1FFFFF, 21'h0003FF, 21'h1FF000, 6'd2, 6'h3E, 2'b00, 6'd1);
    run("basic_pos",  21'h1FFFFF, 21'h0003FF, 21'h1FF000, 6'd1, 6'h3E, 2'b01, 6'd1);
    run("overlap",    21'h1FFFFF, 21'h00000F, 21'h0000FF, 6'd2, 6'h3C, 2'b00, 6'd0);
    run("neg_full",   21'h1FFFFF, 21'h000000, 21'h1FFFFF, 6'd5, 6'h3C, 2'b11, 6'h2B);
    run("prio",       21'h000000, 21'h0F0F0F, 21'h10F0F0, 6'h3D, 6'd3, 2'b01, 6'd0);

    // Abort mid-POS: no result may surface afterwards.
    send(21'h1FFFFF, 21'h1FFFFF, 21'h0, 6'd1, 6'd0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("abort_rel_in_ready", in_ready, 1);
    check("abort_out_act", out_act, 0);
`ifdef TNN_DIFF_OUT_EN
    check("abort_out_diff", out_diff, 0);
`endif
    repeat (10) @(posedge clk);
    #1;

    // Backpressure: result must hold and a new request must be ignored.
    out_ready = 1'b0;
    send(21'h1FFFFF, 21'h0003FF, 21'h1FF000, 6'd1, 6'h3E);
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      in_x = 21'h0; in_pos = 21'h0; in_neg = 21'h1FFFFF; in_valid = 1'b1;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_act", out_act, 2'b01);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    @(posedge clk); #1;

    // Back-to-back with timing checks.
    lat_chk = 1'b1;
    prev_acc = -1;
    for (int i = 0; i < 8; i++) begin
      send(21'($urandom), 21'($urandom), 21'($urandom), 6'($urandom), 6'($urandom));
    end
    drain();
    lat_chk = 1'b0;

    // Random traffic with random consumer stalls.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          send(21'($urandom), 21'($urandom), 21'($urandom), 6'($urandom), 6'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
